// File: rtl/seg_display_rx.sv
// seg_display_rx
//   Sink for two-digit result frames. Each accepted frame is latched, decoded to
//   seven-segment patterns and scanned onto a 2-digit common-anode display. Each
//   frame is held on screen for HOLD_CYCLES cycles before the next can be accepted.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   s_valid    frame valid from upstream
//   s_ready    block can accept a frame (registered state, no path from s_valid)
//   s_data     digit codes, [0]=ones, [1]=tens; codes >9 are error markers
//   an         digit anodes, active-low; an[0]=ones, an[1]=tens
//   seg        cathodes {g,f,e,d,c,b,a}, active-low
//   bad_code   one-cycle pulse after accepting a frame containing a code >9
//   frame_cnt  number of accepted frames, wraps at 256
//
// States
//   IDLE | waiting for a frame, s_ready high
//   HOLD | frame just accepted, s_ready low for HOLD_CYCLES cycles

module seg_display_rx #(
    parameter int HOLD_CYCLES    = 4,
    parameter int REFRESH_CYCLES = 4,
    parameter int LZ_BLANK       = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [1:0][6:0] s_data,
    output logic [1:0]      an,
    output logic [6:0]      seg,
    output logic            bad_code,
    output logic [7:0]      frame_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, next_state;
    logic [HW-1:0]   hold_cnt;
    logic [RW-1:0]   ref_cnt;
    logic            sel;
    logic            shown;
    logic [1:0][6:0] disp_reg;
    logic            transfer;
    logic            code_bad;
    logic [6:0]      cur_code;
    logic            cur_blank;
    logic [6:0]      pattern;

    function automatic logic [6:0] decode(input logic [6:0] code);
        logic [6:0] p;
        case (code)
            7'd0:    p = 7'h3F;
            7'd1:    p = 7'h06;
            7'd2:    p = 7'h5B;
            7'd3:    p = 7'h4F;
            7'd4:    p = 7'h66;
            7'd5:    p = 7'h6D;
            7'd6:    p = 7'h7D;
            7'd7:    p = 7'h07;
            7'd8:    p = 7'h7F;
            7'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    assign s_ready  = (state == IDLE);
    assign transfer = s_valid && s_ready;
    assign code_bad = (s_data[0] > 7'd9) || (s_data[1] > 7'd9);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (transfer) next_state = HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt  <= '0;
            disp_reg  <= '0;
            shown     <= 1'b0;
            frame_cnt <= 8'd0;
            bad_code  <= 1'b0;
        end else begin
            bad_code <= 1'b0;
            if (transfer) begin
                disp_reg  <= s_data;
                shown     <= 1'b1;
                hold_cnt  <= '0;
                frame_cnt <= frame_cnt + 8'd1;
                bad_code  <= code_bad;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_cnt <= '0;
            sel     <= 1'b0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            sel     <= ~sel;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    // Leading-zero blanking applies to the tens digit only.
    always_comb begin
        cur_code  = sel ? disp_reg[1] : disp_reg[0];
        cur_blank = !shown || (sel && (LZ_BLANK != 0) && (disp_reg[1] == 7'd0));
        pattern   = cur_blank ? 7'h00 : decode(cur_code);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= 2'b11;
            seg <= 7'h7F;
        end else begin
            an  <= sel ? 2'b01 : 2'b10;
            seg <= ~pattern;
        end
    end

endmodule
